sdp_ram_be: RTL and testbench

//  Parametrised simple dual-port RAM: one write port with byte enables, one read port.

---
 rtl/sdp_ram_be.sv | 176 +++++++++++++++++
 tb/tb_sdp_ram_be.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// sdp_ram_be
//   Simple dual-port RAM: one write port with per-lane byte enables and one read port.
//   After reset every word is cleared to zero by an init sequence. Read-during-write
//   behaviour is selectable. The output register stage is optional. A one-cycle strobe
//   marks each read result.
//
// Ports
//   clk    rising-edge clock for all logic
//   rst    synchronous reset, active high
//   busy   high while in reset or while the init clear runs; port requests are ignored then
//   wen    write request; wbe selects lanes, waddr/wdat give address and data
//   ren    read request for raddr
//   q      read data; changes only when q_vld is high, otherwise holds
//   q_vld  one pulse per accepted read, 2 (OUT_REG=0) or 3 (OUT_REG=1) cycles after ren
//
// Request/strobe semantics: there is no back-pressure. A request is taken on every rising
// edge where busy is low. Each taken read produces exactly one q_vld pulse after a fixed
// latency. If reset arrives first, the read is discarded instead.

module sdp_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 1 << ADDR_WIDTH,
   parameter int OUT_REG    = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             busy,
   input  logic                             wen,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            wdat,
   input  logic                             ren,
   input  logic [ADDR_WIDTH-1:0]            raddr,
   output logic [DATA_WIDTH-1:0]            q,
   output logic                             q_vld
);

   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_V   = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
   logic                    clr_we;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    s0_wen, s0_ren;
   logic [NB-1:0]           s0_wbe;
   logic [ADDR_WIDTH-1:0]   s0_waddr, s0_raddr;
   logic [DATA_WIDTH-1:0]   s0_wdat;

   logic                    w_in_range, r_in_range;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    rd_vld;

   // ---------------- init / run control ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         ST_INIT: begin
            clr_we = 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_RUN;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign busy = (state_q == ST_INIT);

   // ---------------- stage 0: request capture ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_wen <= 1'b0;
         s0_ren <= 1'b0;
      end else begin
         s0_wen <= wen & ~busy;
         s0_ren <= ren & ~busy;
      end
   end

   always_ff @(posedge clk) begin
      s0_wbe   <= wbe;
      s0_waddr <= waddr;
      s0_wdat  <= wdat;
      s0_raddr <= raddr;
   end

   // Addresses at or above DEPTH do not map to storage.
   assign w_in_range = ({1'b0, s0_waddr} < DEPTH_V);
   assign r_in_range = ({1'b0, s0_raddr} < DEPTH_V);

   // ---------------- stage 1: array access ----------------
   // Gating on !rst keeps a write that was captured just before reset from landing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_cnt_q] <= '0;
         end else if (s0_wen && w_in_range) begin
            for (int i = 0; i < NB; i++) begin
               if (s0_wbe[i])
                  mem[s0_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= s0_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // The array read sees pre-write contents. When RDW_MODE is set, enabled write lanes
   // to the same word are forwarded so the read returns the merged word.
   always_comb begin
      rd_word = '0;
      if (r_in_range) begin
         rd_word = mem[s0_raddr];
         if (RDW_MODE != 0 && s0_wen && w_in_range && s0_waddr == s0_raddr) begin
            for (int i = 0; i < NB; i++) begin
               if (s0_wbe[i])
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = s0_wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_vld <= s0_ren;
         if (s0_ren)
            rd_data <= rd_word;
      end
   end

   // ---------------- stage 2: optional output register ----------------
   generate
      if (OUT_REG != 0) begin : g_oreg
         always_ff @(posedge clk) begin
            if (rst) begin
               q     <= '0;
               q_vld <= 1'b0;
            end else begin
               q_vld <= rd_vld;
               if (rd_vld)
                  q <= rd_data;
            end
         end
      end else begin : g_noreg
         assign q     = rd_data;
         assign q_vld = rd_vld;
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb_sdp_ram_be
//   Three instances share one stimulus stream:
//     u0: DEPTH 8, output register, old data on read-during-write
//     u1: DEPTH 8, no output register, merged data on read-during-write
//     u2: DEPTH 6, output register, merged data on read-during-write
//   A transaction-level reference model predicts busy, q and q_vld for every cycle.
//   A vector table and directed sequences check the specific corner cases.

module tb_sdp_ram_be;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst, wen, ren;
   logic [3:0]  wbe;
   logic [2:0]  waddr, raddr;
   logic [31:0] wdat;
   logic        busy_o  [NI];
   logic        q_vld_o [NI];
   logic [31:0] q_o     [NI];

   int depth_p [NI] = '{8, 8, 6};
   int oreg_p  [NI] = '{1, 0, 1};
   int rdw_p   [NI] = '{0, 1, 1};

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   sdp_ram_be #(.DEPTH(8), .OUT_REG(1), .RDW_MODE(0)) u0 (
      .clk(clk), .rst(rst), .busy(busy_o[0]), .wen(wen), .wbe(wbe), .waddr(waddr),
      .wdat(wdat), .ren(ren), .raddr(raddr), .q(q_o[0]), .q_vld(q_vld_o[0]));
   sdp_ram_be #(.DEPTH(8), .OUT_REG(0), .RDW_MODE(1)) u1 (
      .clk(clk), .rst(rst), .busy(busy_o[1]), .wen(wen), .wbe(wbe), .waddr(waddr),
      .wdat(wdat), .ren(ren), .raddr(raddr), .q(q_o[1]), .q_vld(q_vld_o[1]));
   sdp_ram_be #(.DEPTH(6), .OUT_REG(1), .RDW_MODE(1)) u2 (
      .clk(clk), .rst(rst), .busy(busy_o[2]), .wen(wen), .wbe(wbe), .waddr(waddr),
      .wdat(wdat), .ren(ren), .raddr(raddr), .q(q_o[2]), .q_vld(q_vld_o[2]));

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++)
         if (be[b]) m = m | (32'hFF << (8 * b));
      return (old_w & ~m) | (new_w & m);
   endfunction

   // ---------------- reference model ----------------
   // Each accepted request is held one edge and then resolved against the model memory.
   // If reset arrives before then, the request is dropped. A resolved read is scheduled
   // to appear on q at a fixed edge number.
   typedef struct { int inst; int due; logic [31:0] data; } sb_item_t;
   sb_item_t    exp_q [$];

   logic [31:0] mm [NI][8];
   int          clr_left [NI];
   bit          pend_v [NI], pend_wen [NI], pend_ren [NI];
   logic [3:0]  pend_wbe [NI];
   logic [2:0]  pend_wa [NI], pend_ra [NI];
   logic [31:0] pend_wd [NI];
   logic [31:0] exp_hold [NI];
   bit          exp_vld [NI], exp_busy [NI];
   int          edge_n = 0;
   bit          started = 0;

   task automatic model_step(input int i);
      logic [31:0] v;
      bit acc;
      if (rst) begin
         clr_left[i] = depth_p[i];
         pend_v[i]   = 0;
         exp_hold[i] = '0;
         exp_vld[i]  = 0;
         exp_busy[i] = 1;
         for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].inst == i) exp_q.delete(j);
         return;
      end
      if (pend_v[i]) begin
         if (pend_ren[i]) begin
            v = '0;
            if (int'(pend_ra[i]) < depth_p[i]) begin
               v = mm[i][pend_ra[i]];
               if (rdw_p[i] != 0 && pend_wen[i] && pend_wa[i] == pend_ra[i])
                  v = merge(v, pend_wd[i], pend_wbe[i]);
            end
            exp_q.push_back('{inst: i, due: edge_n + oreg_p[i], data: v});
         end
         if (pend_wen[i] && int'(pend_wa[i]) < depth_p[i])
            mm[i][pend_wa[i]] = merge(mm[i][pend_wa[i]], pend_wd[i], pend_wbe[i]);
         pend_v[i] = 0;
      end
      acc = (clr_left[i] == 0);
      if (clr_left[i] > 0) begin
         clr_left[i]--;
         if (clr_left[i] == 0)
            for (int a = 0; a < 8; a++) mm[i][a] = '0;
      end
      if (acc && (wen || ren)) begin
         pend_v[i]   = 1;
         pend_wen[i] = wen;
         pend_ren[i] = ren;
         pend_wbe[i] = wbe;
         pend_wa[i]  = waddr;
         pend_ra[i]  = raddr;
         pend_wd[i]  = wdat;
      end
      exp_busy[i] = (clr_left[i] > 0);
      exp_vld[i]  = 0;
      for (int j = 0; j < exp_q.size(); j++) begin
         if (exp_q[j].inst == i) begin
            if (exp_q[j].due == edge_n) begin
               exp_vld[i]  = 1;
               exp_hold[i] = exp_q[j].data;
               exp_q.delete(j);
            end
            break;
         end
      end
   endtask

   always @(posedge clk) begin
      edge_n++;
      if (rst) started = 1;
      for (int i = 0; i < NI; i++) model_step(i);
   end

   // ---------------- cycle scoreboard ----------------
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("busy_u%0d", i), 32'(busy_o[i]), 32'(exp_busy[i]));
            check($sformatf("q_vld_u%0d", i), 32'(q_vld_o[i]), 32'(exp_vld[i]));
            check($sformatf("q_u%0d", i), q_o[i], exp_hold[i]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      wen = 0;
      ren = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input bit w, input logic [2:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit r, input logic [2:0] ra);
      wen = w; waddr = wa; wdat = wd; wbe = be; ren = r; raddr = ra;
      @(negedge clk);
      wen = 0;
      ren = 0;
   endtask

   // Call right after rst is released; busy must fall exactly DEPTH cycles later.
   task automatic wait_clear(input string tag);
      int fell [NI];
      for (int i = 0; i < NI; i++) fell[i] = -1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++)
            if (fell[i] < 0 && !busy_o[i]) fell[i] = k;
      end
      for (int i = 0; i < NI; i++)
         check($sformatf("%s_u%0d", tag, i), 32'(fell[i]), 32'(depth_p[i]));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          w;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          same_cyc;
      logic [2:0]  ra;
      logic [31:0] e0, e1, e2;
   } vec_t;

   vec_t vt [12];

   initial begin
      logic [8:0] vm [NI];

      vt[0]  = '{1, 3'd3, 32'hAABBCCDD, 4'hF, 0, 3'd3, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD};
      vt[1]  = '{1, 3'd3, 32'h11223344, 4'h5, 0, 3'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
      vt[2]  = '{1, 3'd3, 32'hFFFFFFFF, 4'h0, 0, 3'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
      vt[3]  = '{1, 3'd7, 32'h5A5A5A5A, 4'hF, 0, 3'd7, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000};
      vt[4]  = '{1, 3'd6, 32'h12345678, 4'h8, 0, 3'd6, 32'h12000000, 32'h12000000, 32'h00000000};
      vt[5]  = '{1, 3'd0, 32'hCAFEF00D, 4'h3, 0, 3'd0, 32'h0000F00D, 32'h0000F00D, 32'h0000F00D};
      vt[6]  = '{0, 3'd0, 32'h0,        4'h0, 0, 3'd5, 32'h00000000, 32'h00000000, 32'h00000000};
      vt[7]  = '{1, 3'd5, 32'hDEADBEEF, 4'hF, 1, 3'd5, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[8]  = '{0, 3'd0, 32'h0,        4'h0, 0, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[9]  = '{1, 3'd3, 32'h00009999, 4'h3, 1, 3'd3, 32'hAA22CC44, 32'hAA229999, 32'hAA229999};
      vt[10] = '{0, 3'd0, 32'h0,        4'h0, 0, 3'd3, 32'hAA229999, 32'hAA229999, 32'hAA229999};
      vt[11] = '{1, 3'd4, 32'h13579BDF, 4'hF, 0, 3'd4, 32'h13579BDF, 32'h13579BDF, 32'h13579BDF};

      rst = 1; wen = 0; ren = 0; wbe = '0; waddr = '0; raddr = '0; wdat = '0;
      repeat (2) @(negedge clk);

      // Init clear length after a reset.
      rst = 0;
      wait_clear("clear_len");
      idle(1);

      // Table: optional write, then a read (or both in the same cycle), then let q settle.
      for (int v = 0; v < 12; v++) begin
         if (vt[v].same_cyc) begin
            drive(1, vt[v].wa, vt[v].wd, vt[v].be, 1, vt[v].ra);
         end else begin
            if (vt[v].w) drive(1, vt[v].wa, vt[v].wd, vt[v].be, 0, 3'd0);
            drive(0, 3'd0, 32'h0, 4'h0, 1, vt[v].ra);
         end
         idle(4);
         check($sformatf("vec%0d_u0", v), q_o[0], vt[v].e0);
         check($sformatf("vec%0d_u1", v), q_o[1], vt[v].e1);
         check($sformatf("vec%0d_u2", v), q_o[2], vt[v].e2);
      end

      // Burst of four reads on addrs 0..3: q_vld pulse positions, then q holds the addr-3 word.
      for (int i = 0; i < NI; i++) vm[i] = '0;
      ren = 1; raddr = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) vm[i][k] = q_vld_o[i];
         if (k < 4) raddr = 3'(k);
         else       ren = 0;
      end
      for (int i = 0; i < NI; i++) begin
         check($sformatf("burst_vld_u%0d", i), 32'(vm[i]), (oreg_p[i] != 0) ? 32'h078 : 32'h03C);
         check($sformatf("burst_hold_u%0d", i), q_o[i], 32'hAA229999);
      end

      // Reset with a read in flight: no strobe, q returns to zero.
      drive(0, 3'd0, 32'h0, 4'h0, 1, 3'd3);
      rst = 1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) check($sformatf("rst_flush_q_u%0d", i), q_o[i], 32'h0);
      rst = 0;
      wait_clear("clear_after_flush");

      // Reset pulsed part-way through the clear restarts it from word 0.
      rst = 1;
      @(negedge clk);
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) check($sformatf("busy_mid_u%0d", i), 32'(busy_o[i]), 32'h1);
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      wait_clear("clear_restart");

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1; wen = 0; ren = 0;
            @(negedge clk);
            rst = 0;
         end else begin
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            wbe   = 4'($urandom_range(0, 15));
            waddr = 3'($urandom_range(0, 7));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            wdat  = $urandom;
            @(negedge clk);
         end
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
